// File: rtl/servo_pwm_decoder_pkg.sv
// Shared constants and FSM encoding for the servo PWM decode path.
package servo_pkg;

    localparam logic [7:0] ANGLE_MAX = 8'd180;
    localparam logic [7:0] ANGLE_RST = 8'd90;

    typedef enum logic [1:0] {
        SYNC      = 2'd0,
        WAIT_RISE = 2'd1,
        HIGH      = 2'd2
    } state_e;

endpackage

// File: rtl/servo_pwm_decoder_filter.sv
// Two-flop synchronizer plus glitch filter for slow pin inputs; strobes mark filtered edges.
module pwm_in_filter #(
    parameter int GLITCH_CYC = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic pin_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int GW = $clog2(GLITCH_CYC + 1);

    logic          sync1_q, sync2_q;
    logic          level_q, rise_q, fall_q;
    logic [GW-1:0] cnt_q;

    // Level resets high so a pulse already in progress is never seen as a fresh rise.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= pin_i;
            sync2_q <= sync1_q;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            if (sync2_q != level_q) begin
                if (cnt_q == GW'(GLITCH_CYC - 1)) begin
                    level_q <= sync2_q;
                    rise_q  <= sync2_q;
                    fall_q  <= ~sync2_q;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/servo_pwm_decoder.sv
// Measures servo PWM high time and converts it to a 0..180 angle code without a divider.
module servo_pwm_decoder
    import servo_pkg::*;
#(
    parameter int CLK_MHZ      = 50,
    parameter int MIN_PULSE_US = 500,
    parameter int MAX_PULSE_US = 2500,
    parameter int TIMEOUT_US   = 25000,
    parameter int GLITCH_CYC   = 4,
    parameter int CNT_W        = 21
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    output logic [7:0]       angle,
    output logic             angle_valid,
    output logic [CNT_W-1:0] pulse_cycles,
    output logic             range_err,
    output logic             signal_lost
);

    localparam int MIN_CYC = MIN_PULSE_US * CLK_MHZ;
    localparam int MAX_CYC = MAX_PULSE_US * CLK_MHZ;
    localparam int TO_CYC  = TIMEOUT_US * CLK_MHZ;
    localparam int DEG_CYC = (MAX_CYC - MIN_CYC) / 180;

    localparam logic [CNT_W-1:0] MIN_C   = CNT_W'(MIN_CYC);
    localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(MAX_CYC);
    localparam logic [CNT_W-1:0] TO_C    = CNT_W'(TO_CYC);
    localparam logic [CNT_W-1:0] DEG_END = CNT_W'(DEG_CYC - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic [CNT_W-1:0] lim);
        return (v >= lim) ? v : v + 1'b1;
    endfunction

    logic level, rise, fall;

    pwm_in_filter #(.GLITCH_CYC(GLITCH_CYC)) u_filter (
        .clk     (clk),
        .rst     (rst),
        .pin_i   (pwm_in),
        .level_o (level),
        .rise_o  (rise),
        .fall_o  (fall)
    );

    state_e           state_q, state_d;
    logic             publish, stuck;
    logic [CNT_W-1:0] width_q, pre_q, wd_q, width_inc;
    logic [7:0]       deg_q;

    always_ff @(posedge clk) begin
        if (rst) state_q <= SYNC;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        publish = 1'b0;
        stuck   = 1'b0;
        case (state_q)
            SYNC:      if (!level) state_d = WAIT_RISE;
            WAIT_RISE: if (rise)   state_d = HIGH;
            HIGH: begin
                if (fall) begin
                    state_d = WAIT_RISE;
                    publish = 1'b1;
                end else if (width_q == TO_C) begin
                    state_d = SYNC;
                    stuck   = 1'b1;
                end
            end
            default:   state_d = SYNC;
        endcase
    end

    assign width_inc = sat_inc(width_q, TO_C);

    // Width counts filtered-high cycles, so at the fall strobe width_q equals the pulse length.
    always_ff @(posedge clk) begin
        if (rst) begin
            width_q      <= '0;
            pre_q        <= '0;
            deg_q        <= '0;
            wd_q         <= '0;
            angle        <= ANGLE_RST;
            pulse_cycles <= '0;
            angle_valid  <= 1'b0;
            range_err    <= 1'b0;
            signal_lost  <= 1'b1;
        end else begin
            angle_valid <= publish;
            wd_q        <= rise ? '0 : sat_inc(wd_q, TO_C);

            if (state_q == WAIT_RISE && rise) begin
                width_q <= CNT_W'(1);
                pre_q   <= '0;
                deg_q   <= '0;
            end else if (state_q == HIGH && !fall) begin
                width_q <= width_inc;
                if (width_inc > MIN_C && width_inc != width_q) begin
                    if (pre_q == DEG_END) begin
                        pre_q <= '0;
                        if (deg_q < ANGLE_MAX) deg_q <= deg_q + 8'd1;
                    end else begin
                        pre_q <= pre_q + 1'b1;
                    end
                end
            end

            if (publish) begin
                angle        <= (width_q > MAX_C) ? ANGLE_MAX : deg_q;
                pulse_cycles <= width_q;
                range_err    <= (width_q < MIN_C) || (width_q > MAX_C);
                signal_lost  <= 1'b0;
            end else if (stuck || wd_q == TO_C) begin
                signal_lost  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// Bench for servo_pwm_decoder, scaled to a 1 MHz clock so every timing case fits a short run.
module tb_servo_pwm_decoder;

    localparam int CLK_MHZ    = 1;
    localparam int MIN_US     = 500;
    localparam int MAX_US     = 2500;
    localparam int TO_US      = 10000;
    localparam int GLITCH     = 4;
    localparam int CNT_W      = 21;
    localparam int TO_CYC     = TO_US * CLK_MHZ;
    localparam int NVEC       = 12;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             pwm_in = 1'b0;
    logic [7:0]       angle;
    logic             angle_valid;
    logic [CNT_W-1:0] pulse_cycles;
    logic             range_err;
    logic             signal_lost;

    servo_pwm_decoder #(
        .CLK_MHZ      (CLK_MHZ),
        .MIN_PULSE_US (MIN_US),
        .MAX_PULSE_US (MAX_US),
        .TIMEOUT_US   (TO_US),
        .GLITCH_CYC   (GLITCH),
        .CNT_W        (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pwm_in       (pwm_in),
        .angle        (angle),
        .angle_valid  (angle_valid),
        .pulse_cycles (pulse_cycles),
        .range_err    (range_err),
        .signal_lost  (signal_lost)
    );

    always #5 clk = ~clk;

    typedef struct {
        int high_cyc;
        int low_cyc;
        int exp_angle;
        bit exp_err;
    } vec_t;

    typedef struct {
        int angle;
        int pulse;
        bit err;
    } exp_t;

    vec_t vecs [NVEC];
    exp_t sb_q [$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   strobe_cnt = 0;
    int   last_angle = 90;
    int   last_pulse = 0;
    int   last_err   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard side: every strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && angle_valid) begin
            exp_t e;
            strobe_cnt++;
            if (sb_q.size() == 0) begin
                check("unexpected_strobe", 1, 0);
            end else begin
                e = sb_q.pop_front();
                check("angle", int'(angle), e.angle);
                check("pulse_cycles", int'(pulse_cycles), e.pulse);
                check("range_err", int'(range_err), int'(e.err));
                check("signal_lost_at_strobe", int'(signal_lost), 0);
            end
        end
    end

    task automatic pulse_expect(input int hi, input int lo, input int exp_angle, input bit exp_err);
        exp_t e;
        bit   seen;
        e.angle = exp_angle;
        e.pulse = hi;
        e.err   = exp_err;
        sb_q.push_back(e);
        last_angle = exp_angle;
        last_pulse = hi;
        last_err   = int'(exp_err);
        @(posedge clk); #1 pwm_in = 1'b1;
        repeat (hi) @(posedge clk);
        #1 pwm_in = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (angle_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check("strobe_latency_bound", int'(seen), 1);
        repeat (lo) @(posedge clk);
    endtask

    task automatic check_held(input string tag);
        check({tag, "_angle"}, int'(angle), last_angle);
        check({tag, "_pulse"}, int'(pulse_cycles), last_pulse);
        check({tag, "_err"}, int'(range_err), last_err);
    endtask

    initial begin
        int s0;

        vecs[0]  = '{1500, 150,  90, 1'b0};
        vecs[1]  = '{ 500, 150,   0, 1'b0};
        vecs[2]  = '{2500, 150, 180, 1'b0};
        vecs[3]  = '{ 400, 150,   0, 1'b1};
        vecs[4]  = '{3000, 150, 180, 1'b1};
        vecs[5]  = '{1000, 150,  45, 1'b0};
        vecs[6]  = '{ 511, 150,   1, 1'b0};
        vecs[7]  = '{ 510, 150,   0, 1'b0};
        vecs[8]  = '{1510, 150,  91, 1'b0};
        vecs[9]  = '{2480, 150, 180, 1'b0};
        vecs[10] = '{ 499, 150,   0, 1'b1};
        vecs[11] = '{2501, 150, 180, 1'b1};

        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        repeat (20) @(negedge clk);
        check("rst_angle", int'(angle), 90);
        check("rst_pulse", int'(pulse_cycles), 0);
        check("rst_valid", int'(angle_valid), 0);
        check("rst_err", int'(range_err), 0);
        check("rst_lost", int'(signal_lost), 1);

        for (int i = 0; i < NVEC; i++)
            pulse_expect(vecs[i].high_cyc, vecs[i].low_cyc, vecs[i].exp_angle, vecs[i].exp_err);

        // Short high glitch inside the low phase must be swallowed by the filter.
        s0 = strobe_cnt;
        @(posedge clk); #1 pwm_in = 1'b1;
        repeat (2) @(posedge clk);
        #1 pwm_in = 1'b0;
        repeat (50) @(negedge clk);
        check("glitch_no_strobe", strobe_cnt - s0, 0);
        check_held("glitch");
        check("glitch_lost", int'(signal_lost), 0);

        repeat (TO_CYC + 50) @(negedge clk);
        check("watchdog_lost", int'(signal_lost), 1);
        check_held("watchdog");
        pulse_expect(1000, 150, 45, 1'b0);
        check("recover_lost", int'(signal_lost), 0);

        // Input stuck high: loss flagged, nothing published, then normal recovery.
        s0 = strobe_cnt;
        @(posedge clk); #1 pwm_in = 1'b1;
        repeat (TO_CYC + 50) @(posedge clk);
        check("stuck_lost", int'(signal_lost), 1);
        #1 pwm_in = 1'b0;
        repeat (100) @(negedge clk);
        check("stuck_no_strobe", strobe_cnt - s0, 0);
        check_held("stuck");
        pulse_expect(1500, 150, 90, 1'b0);

        // Reset mid-pulse with input still high at release.
        s0 = strobe_cnt;
        @(posedge clk); #1 pwm_in = 1'b1;
        repeat (300) @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_angle", int'(angle), 90);
        check("midrst_pulse", int'(pulse_cycles), 0);
        check("midrst_err", int'(range_err), 0);
        check("midrst_lost", int'(signal_lost), 1);
        repeat (500) @(posedge clk);
        #1 pwm_in = 1'b0;
        repeat (200) @(negedge clk);
        check("midrst_no_strobe", strobe_cnt - s0, 0);
        check("midrst_angle_hold", int'(angle), 90);
        pulse_expect(1500, 150, 90, 1'b0);
        check("midrst_one_strobe", strobe_cnt - s0, 1);

        check("scoreboard_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
